// File: rtl/drain_pkg.sv
// Shared types and geometry helpers for the output drain lane.
package drain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DRAIN
   } drain_state_t;

   function automatic int words_per_line(input int sram_w, input int o_w);
      return sram_w / o_w;
   endfunction

   function automatic int mask_width(input int sram_w);
      return sram_w / 8;
   endfunction

endpackage

// File: rtl/drain_line_fifo.sv
// Flip-flop FIFO of packed {mask, line} entries with count-based flags.
module drain_line_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clear,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_head,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [PW-1:0]           wr_q, rd_q;
   logic [PW:0]             cnt_q;
   logic                    do_push, do_pop;

   assign o_empty = (cnt_q == '0);
   assign o_full  = (cnt_q == (PW+1)'(DEPTH));
   assign o_count = cnt_q;
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;
   // Head is forced to zero while empty so the SRAM bus idles at zero.
   assign o_head  = o_empty ? '0 : mem_q[rd_q];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (i_clear) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wr_q] <= i_data;
   end

endmodule

// File: rtl/drain_xy_lane.sv
// Packs array result words into SRAM lines and writes them out sequentially.
module drain_xy_lane
   import drain_pkg::*;
#(
   parameter int FIFO_POSITIONS = 4,
   parameter int O_W            = 32,
   parameter int SRAM_W         = 128,
   parameter int ADR_W          = 10
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [ADR_W-1:0]     i_base_addr,
   input  logic                 i_flush,
   input  logic                 i_clearfifo,
   input  logic                 i_pipeline_en,
   input  logic                 i_valid,
   input  logic [O_W-1:0]       i_data,
   input  logic                 i_sram_gnt,
   output logic                 o_stall,
   output logic                 o_sram_wren,
   output logic [ADR_W-1:0]     o_sram_addr,
   output logic [SRAM_W-1:0]    o_sram_data,
   output logic [SRAM_W/8-1:0]  o_sram_wmask,
   output logic                 o_busy,
   output logic                 o_done
);
   localparam int N   = words_per_line(SRAM_W, O_W);
   localparam int MW  = mask_width(SRAM_W);
   localparam int BPW = O_W / 8;
   localparam int IW  = (N > 1) ? $clog2(N) : 1;
   localparam int CW  = $clog2(FIFO_POSITIONS) + 1;

   drain_state_t            state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [N-1:0][O_W-1:0]   line_q, line_d;
   logic [ADR_W-1:0]        addr_q, addr_d;
   logic [1:0]              done_pipe_q, done_pipe_d;

   logic                    push, pop, accept;
   logic [SRAM_W-1:0]       push_line;
   logic [MW-1:0]           push_mask, part_mask;
   logic [MW+SRAM_W-1:0]    f_head;
   logic                    f_empty, f_full;
   logic [CW-1:0]           f_count;

   assign o_stall      = (state_q == ST_RUN) && f_full;
   assign accept       = (state_q == ST_RUN) && i_valid && i_pipeline_en && !o_stall;
   assign pop          = !f_empty && i_sram_gnt;
   assign o_sram_wren  = !f_empty;
   assign o_sram_addr  = addr_q;
   assign o_sram_data  = f_head[SRAM_W-1:0];
   assign o_sram_wmask = f_head[MW+SRAM_W-1:SRAM_W];
   assign o_busy       = (state_q != ST_IDLE);
   assign o_done       = done_pipe_q[1];

   always_comb begin
      part_mask = '0;
      for (int j = 0; j < N; j++)
         if (j < int'(idx_q)) part_mask[j*BPW +: BPW] = '1;
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      line_d      = line_q;
      addr_d      = addr_q;
      push        = 1'b0;
      push_line   = line_q;
      push_mask   = '1;
      done_pipe_d = {done_pipe_q[0], 1'b0};
      if (pop) addr_d = addr_q + 1'b1;
      case (state_q)
         ST_IDLE: if (i_start) begin
            state_d = ST_RUN;
            addr_d  = i_base_addr;
            idx_d   = '0;
            line_d  = '0;
         end
         ST_RUN: begin
            if (accept) begin
               line_d[idx_q] = i_data;
               if (idx_q == IW'(N-1)) begin
                  push      = 1'b1;
                  push_line = line_d;
                  line_d    = '0;
                  idx_d     = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            if (i_flush) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (idx_q == '0) begin
               state_d = ST_DRAIN;
            end else if (!f_full) begin
               push      = 1'b1;
               push_mask = part_mask;
               line_d    = '0;
               idx_d     = '0;
               state_d   = ST_DRAIN;
            end
         end
         ST_DRAIN: if (f_count == '0) begin
            state_d        = ST_IDLE;
            done_pipe_d[0] = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      // Clear wins over everything, including a pending done pulse.
      if (i_clearfifo) begin
         state_d     = ST_IDLE;
         idx_d       = '0;
         line_d      = '0;
         addr_d      = '0;
         done_pipe_d = '0;
         push        = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         line_q      <= '0;
         addr_q      <= '0;
         done_pipe_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         line_q      <= line_d;
         addr_q      <= addr_d;
         done_pipe_q <= done_pipe_d;
      end
   end

   drain_line_fifo #(
      .DEPTH (FIFO_POSITIONS),
      .W     (MW + SRAM_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (i_clearfifo),
      .i_push  (push),
      .i_data  ({push_mask, push_line}),
      .i_pop   (pop),
      .o_head  (f_head),
      .o_empty (f_empty),
      .o_full  (f_full),
      .o_count (f_count)
   );

endmodule

// File: tb/tb_drain_xy_lane.sv
// Job table plus hand sequences; a write scoreboard checks every SRAM write.
module tb_drain_xy_lane;
   logic         clk = 1'b0, rst = 1'b1;
   logic         start = 0, flush = 0, clr = 0, pen = 0, valid = 0, gnt = 0;
   logic [9:0]   base = '0;
   logic [31:0]  data = '0;
   logic         stall, wren, busy, done;
   logic [9:0]   addr;
   logic [127:0] wdata;
   logic [15:0]  wmask;

   drain_xy_lane #(.FIFO_POSITIONS(4), .O_W(32), .SRAM_W(128), .ADR_W(10)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base), .i_flush(flush),
      .i_clearfifo(clr), .i_pipeline_en(pen), .i_valid(valid), .i_data(data),
      .i_sram_gnt(gnt), .o_stall(stall), .o_sram_wren(wren), .o_sram_addr(addr),
      .o_sram_data(wdata), .o_sram_wmask(wmask), .o_busy(busy), .o_done(done));

   always #5 clk = ~clk;

   typedef struct { logic [9:0] a; logic [127:0] d; logic [15:0] m; } wr_t;
   typedef struct { logic [9:0] base; int nw; bit hold; int nwr; logic [9:0] la; logic [15:0] lm; } job_t;

   wr_t          exp_q[$];
   job_t         jobs[4];
   int           n_chk = 0, n_fail = 0, wr_cnt = 0, done_cnt = 0;
   logic [9:0]   last_a, maddr;
   logic [15:0]  last_m;
   logic [127:0] mline;
   int           midx;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always begin
      @(negedge clk);
      #2;
      if (!rst) begin
         if (done) done_cnt++;
         if (wren && gnt) begin
            check("sb_pending", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", addr, e.a);
               check("wr_data", wdata, e.d);
               check("wr_mask", wmask, e.m);
            end
            wr_cnt++;
            last_a = addr;
            last_m = wmask;
         end
      end
   end

   task automatic model_accept(input int w);
      mline[midx*32 +: 32] = w;
      midx++;
      if (midx == 4) begin
         exp_q.push_back('{maddr, mline, 16'hFFFF});
         maddr++;
         mline = '0;
         midx = 0;
      end
   endtask

   task automatic begin_job(input logic [9:0] b, input logic g);
      @(negedge clk);
      wr_cnt = 0; done_cnt = 0; gnt = g;
      start = 1; base = b; maddr = b; midx = 0; mline = '0;
      @(negedge clk);
      start = 0;
   endtask

   task automatic feed(input int n, input bit hold);
      int w = 1, guard = 0, scyc = 0;
      bit acc;
      while (w <= n && guard < 500) begin
         @(negedge clk);
         valid = 1; pen = 1; data = w;
         if (stall && hold) begin
            scyc++;
            if (scyc == 1) check("stall_after_16", 128'(w - 1), 128'd16);
            if (scyc == 4) gnt = 1;
         end
         acc = !stall;
         @(posedge clk);
         if (acc) begin
            model_accept(w);
            w++;
         end
         guard++;
      end
      check("feed_timeout", 128'(guard < 500), 128'd1);
      @(negedge clk);
      valid = 0;
   endtask

   task automatic do_flush();
      int t = 0;
      @(negedge clk);
      flush = 1;
      if (midx != 0) begin
         exp_q.push_back('{maddr, mline, 16'((32'd1 << (midx * 4)) - 1)});
         maddr++;
      end
      @(negedge clk);
      flush = 0;
      while (done_cnt == 0 && t < 300) begin
         @(negedge clk);
         #3;
         t++;
      end
      check("done_timeout", 128'(t < 300), 128'd1);
      repeat (5) @(negedge clk);
      #3;
      check("done_single", 128'(done_cnt), 128'd1);
      check("sb_empty", 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      jobs[0] = '{10'h010, 8,  0, 2, 10'h011, 16'hFFFF};
      jobs[1] = '{10'h010, 6,  0, 2, 10'h011, 16'h00FF};
      jobs[2] = '{10'h020, 20, 1, 5, 10'h024, 16'hFFFF};
      jobs[3] = '{10'h3FF, 8,  0, 2, 10'h000, 16'hFFFF};

      #1;
      check("rst_wren", wren, 0);
      check("rst_outs", {stall, busy, done, addr, wdata, wmask}, '0);
      repeat (3) @(negedge clk);
      rst = 0;

      for (int i = 0; i < 4; i++) begin
         begin_job(jobs[i].base, !jobs[i].hold);
         feed(jobs[i].nw, jobs[i].hold);
         do_flush();
         check($sformatf("job%0d_nwr", i), 128'(wr_cnt), 128'(jobs[i].nwr));
         check($sformatf("job%0d_last_addr", i), last_a, jobs[i].la);
         check($sformatf("job%0d_last_mask", i), last_m, jobs[i].lm);
         check($sformatf("job%0d_idle", i), busy, 0);
      end

      // Flush with nothing pending: done exactly one cycle, after the 3rd edge.
      begin_job(10'h100, 1);
      @(negedge clk);
      flush = 1;
      @(posedge clk);
      @(negedge clk);
      flush = 0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         check($sformatf("done_lat_e%0d", k), done, (k == 3));
      end
      check("empty_flush_nwr", 128'(wr_cnt), 128'd0);

      // Clear mid-run with two lines queued.
      begin_job(10'h040, 0);
      feed(8, 0);
      check("clr_pre_wren", wren, 1);
      @(negedge clk);
      clr = 1;
      @(negedge clk);
      clr = 0;
      #1;
      check("clr_wren", wren, 0);
      check("clr_busy", busy, 0);
      exp_q.delete();
      gnt = 1;
      repeat (6) @(negedge clk);
      #3;
      check("clr_no_done", 128'(done_cnt), 128'd0);
      check("clr_no_write", 128'(wr_cnt), 128'd0);

      // Async reset mid-run.
      begin_job(10'h080, 0);
      feed(4, 0);
      check("rst_pre_wren", wren, 1);
      @(negedge clk);
      #2;
      rst = 1;
      #1;
      check("arst_wren", wren, 0);
      check("arst_outs", {stall, busy, done, addr, wdata, wmask}, '0);
      exp_q.delete();
      @(negedge clk);
      rst = 0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/drain_xy_lane.md
# drain_xy_lane

Output-side counterpart of the feeder lane: collects the partial-sum stream leaving one systolic-array edge lane, packs consecutive O_W results into SRAM_W-wide lines with a byte write mask, buffers complete lines in a small FF FIFO, and issues sequential SRAM write requests under a grant handshake. It sits between the array output shift chain and the output SRAM port, and drives `o_stall` back to the array pipeline when line buffering is exhausted.

## Interface
- `FIFO_POSITIONS`, 4: line FIFO depth (power of 2, ≥2)
- `O_W`, 32: result word width (multiple of 8)
- `SRAM_W`, 128: SRAM line width (multiple of O_W); N = SRAM_W/O_W words per line
- `ADR_W`, 10: SRAM line address width
- `i_clk` in 1: clock
- `i_rst` in 1: reset, asynchronous, active-high
- `i_start` in 1: begin drain job; loads `i_base_addr` (IDLE only)
- `i_base_addr` in ADR_W: first line address
- `i_flush` in 1: end of job; write pending partial line, then complete
- `i_clearfifo` in 1: synchronous clear of all lane state
- `i_pipeline_en` in 1: array pipeline enable; input sampled only when high
- `i_valid` in 1: `i_data` holds a valid result
- `i_data` in O_W: result word from array
- `i_sram_gnt` in 1: SRAM accepts current write this cycle
- `o_stall` out 1: array must hold its output word
- `o_sram_wren` out 1: write request
- `o_sram_addr` out ADR_W: line address
- `o_sram_data` out SRAM_W: line data, word 0 in LSBs
- `o_sram_wmask` out SRAM_W/8: byte enables
- `o_busy` out 1: state ≠ IDLE
- `o_done` out 1: one-cycle job-complete pulse

## Operation
- States: IDLE, RUN, FLUSH, DRAIN. Reset/`i_clearfifo` → IDLE, word index `idx`=0, FIFO empty, address counter 0.
- IDLE: `i_start` → RUN, addr ← `i_base_addr`, idx ← 0. `i_start` ignored in other states.
- RUN, accept = `i_valid` && `i_pipeline_en` && !`o_stall`: word written to slot `idx`; idx==N-1 → push line, full mask, idx ← 0, line register zeroed; else idx+1. Unaccepted words are not consumed (array holds them).
- RUN, `i_flush` → FLUSH; a word accepted in the same cycle is included first.
- FLUSH: idx==0 → DRAIN. idx≠0 and FIFO not full → push line, mask = bytes of slots 0..idx-1, unwritten slots zero, idx ← 0, → DRAIN. FIFO full → wait.
- DRAIN: FIFO count==0 → IDLE, `o_done` pulses.
- `i_valid` outside RUN ignored (results dropped).
- Write side (all states): `o_sram_wren` = FIFO non-empty; head line/mask on `o_sram_data`/`o_sram_wmask`. `o_sram_wren` && `i_sram_gnt` → pop, addr+1 mod 2^ADR_W. `o_sram_addr` = address counter.
- `o_stall` = (state==RUN) && FIFO full. Conservative: asserted even if a pop occurs the same cycle.
- Push and pop in the same cycle: count unchanged.

## Timing
- Reset values: `o_stall`=0, `o_sram_wren`=0, `o_sram_addr`=0, `o_sram_data`=0, `o_sram_wmask`=0, `o_busy`=0, `o_done`=0.
- Line pushed at edge k → `o_sram_wren` high in cycle after k (FIFO head combinational from FF storage).
- Sustained throughput: one word/cycle in, one line per N cycles out, with `i_sram_gnt` held high.
- `o_done` registered; with nothing pending, high during the cycle after the 3rd edge following the edge that samples `i_flush`, for one cycle.
- `i_clearfifo` dominates all other inputs; takes effect at the next edge; `o_done` is not generated.
- Async `i_rst` mid-job: all outputs return to reset values immediately; no partial write.

## Structure
- Package `drain_pkg`: state enum `drain_state_t`, function deriving N and mask width from parameters.
- Sub-module `drain_line_fifo`: FF FIFO of {mask, line}, count-based full/empty, sync clear. The packer, FSM and address counter stay in the top.

## Test plan
- N=4, base 0x010, `i_sram_gnt`=1, words 1..8 back-to-back, then flush → writes 0x010 {4,3,2,1} mask 0xFFFF, 0x011 {8,7,6,5} mask 0xFFFF, no third write, single `o_done`.
- 6 words then flush → second write 0x011 data {0,0,6,5}, mask 0x00FF.
- `i_sram_gnt`=0, 20 words offered → `o_stall` asserted after 16 accepted, no word lost. Release grant → 5 writes at consecutive addresses with correct order.
- Base 0x3FF, 8 words → writes at 0x3FF then 0x000.
- Flush with idx=0 and FIFO empty → `o_done` exactly one cycle at the stated latency, no write.
- Assert `i_clearfifo` mid-RUN with 2 lines queued → `o_sram_wren` 0 next cycle, state IDLE, no `o_done`. Assert `i_rst` mid-RUN → outputs zero asynchronously.
